// File: rtl/wb_fifo_axi.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo_axi
// Purpose  : Multi-entry write-back buffer between the dcache victim path and
//            an AXI3 write channel. Holds up to DEPTH dirty lines tagged by
//            line label, supports combinational lookup, byte-masked merge and
//            push coalescing, and drains lines oldest-first as INCR bursts of
//            32-bit beats with a single outstanding transaction.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            aw*/w*/b*         - AXI3 write address / data / response channels
//            pline, push       - {label, data} enqueue request
//            pushed            - enqueue accepted this cycle (combinational)
//            full, empty       - occupancy status (empty also needs FSM idle)
//            query_label       - lookup label
//            query_found       - label hits a valid entry
//            query_on_pop      - hit is the head entry currently draining
//            query_rdata       - data of the hit entry, zero on miss
//            query_wdata/wbe   - byte-masked merge data / enables
//            write, written    - merge request / merge accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo_axi #(
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int AWID       = 1,
  localparam int OFFSET_W    = $clog2(LINE_WIDTH / 8),
  localparam int LABEL_WIDTH = 32 - OFFSET_W,
  localparam int BEATS       = LINE_WIDTH / 32,
  localparam int BE_W        = LINE_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  // AXI3 write address channel
  output logic [ID_WIDTH-1:0]             awid,
  output logic [31:0]                     awaddr,
  output logic [3:0]                      awlen,
  output logic [2:0]                      awsize,
  output logic [1:0]                      awburst,
  output logic                            awvalid,
  input  logic                            awready,
  // AXI3 write data channel
  output logic [ID_WIDTH-1:0]             wid,
  output logic [31:0]                     wdata,
  output logic [3:0]                      wstrb,
  output logic                            wlast,
  output logic                            wvalid,
  input  logic                            wready,
  // AXI3 write response channel
  input  logic [ID_WIDTH-1:0]             bid,
  input  logic [1:0]                      bresp,
  input  logic                            bvalid,
  output logic                            bready,
  // Enqueue side
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] pline,
  input  logic                            push,
  output logic                            pushed,
  output logic                            full,
  output logic                            empty,
  // Lookup / merge side
  input  logic [LABEL_WIDTH-1:0]          query_label,
  output logic                            query_found,
  output logic                            query_on_pop,
  output logic [LINE_WIDTH-1:0]           query_rdata,
  input  logic [LINE_WIDTH-1:0]           query_wdata,
  input  logic [BE_W-1:0]                 query_wbe,
  input  logic                            write,
  output logic                            written
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [DEPTH-1:0]       r_valid;
  logic [LABEL_WIDTH-1:0] r_label [DEPTH];
  logic [LINE_WIDTH-1:0]  r_data  [DEPTH];
  logic [LINE_WIDTH-1:0]  w_data_nxt [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [PTR_W:0]         r_count;
  logic [BEAT_W-1:0]      r_beat;
  logic [31:0]            r_awaddr;

  logic [LABEL_WIDTH-1:0] w_push_label;
  logic [LINE_WIDTH-1:0]  w_push_data;
  logic                   w_draining;
  logic                   w_q_hit;
  logic [PTR_W-1:0]       w_q_idx;
  logic                   w_c_hit;
  logic [PTR_W-1:0]       w_c_idx;
  logic [PTR_W-1:0]       w_scan;
  logic                   w_alloc;
  logic                   w_pop;
  logic                   w_unused_axi;

  assign w_push_label = pline[LINE_WIDTH +: LABEL_WIDTH];
  assign w_push_data  = pline[LINE_WIDTH-1:0];
  // The head is owned by the drain engine from the moment its address is latched.
  assign w_draining   = (r_state != S_IDLE);
  assign w_unused_axi = ^{bid, bresp};

  // Lookups scan oldest to youngest so the last hit is the youngest entry.
  // Coalescing skips the draining head; that is the only way a duplicate
  // label can enter the buffer, and the duplicate is always younger.
  always_comb begin
    w_q_hit = 1'b0;
    w_q_idx = '0;
    w_c_hit = 1'b0;
    w_c_idx = '0;
    w_scan  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan = r_head + k[PTR_W-1:0];
      if (r_valid[w_scan] && (r_label[w_scan] == query_label)) begin
        w_q_hit = 1'b1;
        w_q_idx = w_scan;
      end
      if (r_valid[w_scan] && (r_label[w_scan] == w_push_label) &&
          !(w_draining && (w_scan == r_head))) begin
        w_c_hit = 1'b1;
        w_c_idx = w_scan;
      end
    end
  end

  assign full         = (r_count == (PTR_W+1)'(DEPTH));
  assign empty        = (r_count == '0) && (r_state == S_IDLE);
  assign query_found  = w_q_hit;
  assign query_on_pop = w_q_hit && w_draining && (w_q_idx == r_head);
  assign query_rdata  = w_q_hit ? r_data[w_q_idx] : '0;
  assign pushed       = push && (w_c_hit || !full);
  assign written      = write && query_found && !query_on_pop;
  assign w_alloc      = push && !w_c_hit && !full;
  assign w_pop        = (r_state == S_B) && bvalid;

  // Next line contents: push data first, merge bytes on top so a same-cycle
  // write overrides pline for the bytes it enables.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_data_nxt[e] = r_data[e];
      if ((w_alloc && (r_tail == PTR_W'(e))) ||
          (push && w_c_hit && (w_c_idx == PTR_W'(e)))) begin
        w_data_nxt[e] = w_push_data;
      end
      if (written && (w_q_idx == PTR_W'(e))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (query_wbe[b]) begin
            w_data_nxt[e][b*8 +: 8] = query_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Line storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    r_data <= w_data_nxt;
    if (w_alloc) begin
      r_label[r_tail] <= w_push_label;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_pop);
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_count != '0)      w_state_nxt = S_AW;
      S_AW:   if (awready)            w_state_nxt = S_W;
      S_W:    if (wready && wlast)    w_state_nxt = S_B;
      S_B:    if (bvalid)             w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b1;
    case (r_state)
      S_AW: awvalid = 1'b1;
      S_W: begin
        wvalid = 1'b1;
        wlast  = (r_beat == BEAT_W'(BEATS - 1));
      end
      default: ;
    endcase
  end

  // Beat counter and latched burst address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat   <= '0;
      r_awaddr <= '0;
    end else begin
      if (r_state == S_IDLE && r_count != '0) begin
        r_awaddr <= {r_label[r_head], {OFFSET_W{1'b0}}};
      end
      if (r_state == S_AW && awready) begin
        r_beat <= '0;
      end else if (r_state == S_W && wready) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign awid    = ID_WIDTH'(AWID);
  assign wid     = ID_WIDTH'(AWID);
  assign awaddr  = r_awaddr;
  assign awlen   = 4'(BEATS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;
  assign wdata   = r_data[r_head][{r_beat, 5'b0} +: 32];

endmodule
`default_nettype wire

// File: tb/tb_wb_fifo_axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fifo_axi
// Purpose  : Self-checking bench for wb_fifo_axi with a queue-based reference
//            model of the buffer and a simple AXI3 write slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_fifo_axi;

  localparam int LW   = 256;
  localparam int D    = 4;
  localparam int LABW = 27;
  localparam int NB   = 8;
  localparam int BEW  = 32;

  logic            clk, rst;
  logic [3:0]      awid, wid, bid;
  logic [31:0]     awaddr, wdata;
  logic [3:0]      awlen, wstrb;
  logic [2:0]      awsize;
  logic [1:0]      awburst, bresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [LABW+LW-1:0] pline;
  logic            push, pushed, full, empty;
  logic [LABW-1:0] query_label;
  logic            query_found, query_on_pop;
  logic [LW-1:0]   query_rdata, query_wdata;
  logic [BEW-1:0]  query_wbe;
  logic            write, written;

  wb_fifo_axi dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .pline(pline), .push(push), .pushed(pushed), .full(full), .empty(empty),
    .query_label(query_label), .query_found(query_found),
    .query_on_pop(query_on_pop), .query_rdata(query_rdata),
    .query_wdata(query_wdata), .query_wbe(query_wbe),
    .write(write), .written(written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [LABW-1:0] label;
    logic [LW-1:0]   data;
  } ent_t;

  ent_t        mq[$];          // oldest first
  bit          m_drain;        // front entry owned by the drain engine
  bit          m_in_b;         // all beats sent, waiting for response
  int          m_beat;
  logic [31:0] aw_log[$];
  logic [31:0] beat_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // slave controls
  bit aw_low = 0, w_rand = 0, b_arm = 0, b_clear = 0, b_pend = 0;
  int b_delay = 0, b_cnt = 0;

  function automatic int find_young(input logic [LABW-1:0] lab);
    int r = -1;
    for (int i = 0; i < mq.size(); i++) if (mq[i].label == lab) r = i;
    return r;
  endfunction

  function automatic int find_coal(input logic [LABW-1:0] lab);
    int r = -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].label == lab && !(i == 0 && m_drain)) r = i;
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // AXI3 write slave
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin bvalid = 1'b0; b_pend = 0; b_clear = 0; end
      awready = aw_low ? 1'b0 : 1'b1;
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_clear) begin bvalid = 1'b0; b_pend = 0; b_clear = 0; end
      if (b_arm) begin b_pend = 1; b_cnt = b_delay; b_arm = 0; end
      if (b_pend && !bvalid) begin
        if (b_cnt == 0) bvalid = 1'b1; else b_cnt--;
      end
    end
  end

  // Channel monitor and model update, mid-cycle with inputs stable
  always @(negedge clk) begin
    int   ct, wt;
    bit   start, do_pop;
    ent_t e;
    logic [31:0] exp_w;
    if (rst) begin
      mq.delete(); m_drain = 0; m_in_b = 0; m_beat = 0; b_arm = 0;
    end else begin
      start  = !m_drain && (mq.size() != 0);
      do_pop = 0;
      if (awvalid && awready) begin
        aw_log.push_back(awaddr);
        n_checks++;
        if (!m_drain || mq.size() == 0 || awaddr !== {mq[0].label, 5'b0} ||
            {awlen, awsize, awburst} !== {4'd7, 3'b010, 2'b01}) begin
          n_fail++;
          $display("FAIL aw_channel: got addr=%h len=%0d want addr=%h len=7",
                   awaddr, awlen, (mq.size() != 0) ? {mq[0].label, 5'b0} : 32'h0);
        end
      end
      if (wvalid && wready) begin
        beat_log.push_back(wdata);
        n_checks++;
        if (mq.size() == 0) begin
          n_fail++;
          $display("FAIL w_beat: got %h with no queued line", wdata);
        end else begin
          e = mq[0];
          exp_w = e.data[m_beat*32 +: 32];
          if (wdata !== exp_w || wlast !== 1'(m_beat == NB-1) || wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL w_beat%0d: got data=%h last=%b want data=%h last=%b",
                     m_beat, wdata, wlast, exp_w, (m_beat == NB-1));
          end
        end
        if (m_beat == NB-1) begin m_beat = 0; m_in_b = 1; b_arm = 1; end
        else m_beat++;
      end
      if (bvalid && bready) begin
        b_clear = 1;
        if (m_in_b) do_pop = 1;
      end
      wt = find_young(query_label);
      ct = find_coal(pline[LW +: LABW]);
      if (push) begin
        if (ct >= 0) begin
          e = mq[ct]; e.data = pline[LW-1:0]; mq[ct] = e;
        end else if (mq.size() < D) begin
          e.label = pline[LW +: LABW]; e.data = pline[LW-1:0];
          mq.push_back(e);
        end
      end
      if (write && wt >= 0 && !(wt == 0 && m_drain)) begin
        e = mq[wt];
        for (int b = 0; b < BEW; b++)
          if (query_wbe[b]) e.data[b*8 +: 8] = query_wdata[b*8 +: 8];
        mq[wt] = e;
      end
      if (do_pop) begin
        void'(mq.pop_front()); m_drain = 0; m_in_b = 0;
      end
      if (start) m_drain = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    push = 1'b0; write = 1'b0; pline = '0; query_label = '0;
    query_wdata = '0; query_wbe = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle_in();
    repeat (3) next_cycle();
    #1;
    n_checks++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %b want 0", awvalid); end
    n_checks++; if (wvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_wvalid: got %b want 0", wvalid); end
    n_checks++; if (bready !== 1'b1)  begin n_fail++; $display("FAIL rst_bready: got %b want 1", bready); end
    n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_checks++; if (pushed !== 1'b0 || written !== 1'b0) begin
      n_fail++; $display("FAIL rst_ack: got pushed=%b written=%b want 0 0", pushed, written); end
    n_checks++; if (query_found !== 1'b0 || query_on_pop !== 1'b0) begin
      n_fail++; $display("FAIL rst_query: got found=%b on_pop=%b want 0 0", query_found, query_on_pop); end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_push();
    logic [LW-1:0] d;
    int n;
    aw_low = 0; w_rand = 0; b_delay = 0;
    next_cycle();
    aw_log.delete(); beat_log.delete();
    for (int i = 0; i < NB; i++) d[i*32 +: 32] = 32'hA5A5_0000 + i;
    push = 1'b1; pline = {27'h12345, d};
    #1;
    n_checks++; if (pushed !== 1'b1) begin n_fail++; $display("FAIL single_pushed: got %b want 1", pushed); end
    next_cycle(); idle_in();
    n = 0;
    while (empty !== 1'b1 && n < 40) begin next_cycle(); n++; end
    n_checks++; if (n != 11) begin n_fail++; $display("FAIL drain_latency: got %0d cycles want 11", n); end
    n_checks++;
    if (aw_log.size() != 1 || aw_log[0] !== 32'h0024_68A0) begin
      n_fail++; $display("FAIL single_awaddr: got %0d bursts first=%h want 1 at 002468a0",
                         aw_log.size(), (aw_log.size() != 0) ? aw_log[0] : 32'h0);
    end
    n_checks++;
    if (beat_log.size() != NB) begin n_fail++; $display("FAIL single_beats: got %0d want 8", beat_log.size()); end
    else for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (beat_log[i] !== 32'hA5A5_0000 + i) begin
        n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, beat_log[i], 32'hA5A5_0000 + i);
      end
    end
  endtask

  task automatic test_full_coalesce_merge();
    logic [LABW-1:0] lab [5];
    logic [LW-1:0]   dat [4];
    logic [LW-1:0]   nd;
    int base, n;
    aw_low = 1; next_cycle(); next_cycle();
    aw_log.delete(); beat_log.delete();
    base = $urandom_range(16, 4000) * 8;
    for (int i = 0; i < 5; i++) lab[i] = LABW'(base + i);
    for (int i = 0; i < D; i++) begin
      dat[i] = rand_line();
      push = 1'b1; pline = {lab[i], dat[i]};
      #1;
      n_checks++; if (pushed !== 1'b1) begin n_fail++; $display("FAIL fill_pushed%0d: got %b want 1", i, pushed); end
      next_cycle();
    end
    idle_in(); #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
    next_cycle();
    push = 1'b1; pline = {lab[4], rand_line()}; #1;
    n_checks++; if (pushed !== 1'b0) begin n_fail++; $display("FAIL full_reject: got pushed=%b want 0", pushed); end
    next_cycle();
    nd = rand_line();
    push = 1'b1; pline = {lab[2], nd}; #1;
    n_checks++; if (pushed !== 1'b1) begin n_fail++; $display("FAIL coalesce_pushed: got %b want 1", pushed); end
    next_cycle(); idle_in();
    dat[2] = nd;
    query_label = lab[2]; #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL coalesce_count: got full=%b want 1", full); end
    n_checks++; if (query_rdata !== nd) begin n_fail++; $display("FAIL coalesce_data: got %h want %h", query_rdata, nd); end
    next_cycle();
    // merge into a queued non-head line
    write = 1'b1; query_label = lab[1]; query_wdata = '1; query_wbe = 32'h0000_000F; #1;
    n_checks++; if (written !== 1'b1 || query_on_pop !== 1'b0) begin
      n_fail++; $display("FAIL merge_written: got written=%b on_pop=%b want 1 0", written, query_on_pop); end
    next_cycle();
    // merge into the draining head is refused
    query_label = lab[0]; #1;
    n_checks++; if (query_found !== 1'b1 || query_on_pop !== 1'b1) begin
      n_fail++; $display("FAIL head_query: got found=%b on_pop=%b want 1 1", query_found, query_on_pop); end
    n_checks++; if (written !== 1'b0) begin n_fail++; $display("FAIL head_write: got written=%b want 0", written); end
    next_cycle(); idle_in();
    aw_low = 0;
    n = 0;
    while (empty !== 1'b1 && n < 300) begin next_cycle(); n++; end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain4_timeout: empty=%b", empty); end
    n_checks++;
    if (aw_log.size() != D || beat_log.size() != D*NB) begin
      n_fail++; $display("FAIL drain4_count: got %0d bursts %0d beats want 4 32", aw_log.size(), beat_log.size());
    end else begin
      for (int i = 0; i < D; i++) begin
        n_checks++;
        if (aw_log[i] !== {lab[i], 5'b0}) begin
          n_fail++; $display("FAIL drain4_order%0d: got %h want %h", i, aw_log[i], {lab[i], 5'b0});
        end
      end
      n_checks++;
      if (beat_log[NB] !== 32'hFFFF_FFFF || beat_log[NB+1] !== dat[1][63:32]) begin
        n_fail++; $display("FAIL merge_beats: got %h %h want ffffffff %h", beat_log[NB], beat_log[NB+1], dat[1][63:32]);
      end
      n_checks++;
      if (beat_log[2*NB+3] !== nd[127:96]) begin
        n_fail++; $display("FAIL coalesce_beat: got %h want %h", beat_log[2*NB+3], nd[127:96]);
      end
    end
  endtask

  task automatic test_bdelay();
    logic [LABW-1:0] lab;
    int n;
    w_rand = 1; b_delay = 5; aw_low = 0;
    lab = LABW'($urandom_range(100, 900));
    push = 1'b1; pline = {lab, rand_line()};
    next_cycle(); idle_in();
    query_label = lab;
    n = 0;
    while (bvalid !== 1'b1 && n < 80) begin
      #1;
      n_checks++; if (query_found !== 1'b1 || empty !== 1'b0) begin
        n_fail++; $display("FAIL bdelay_hold: got found=%b empty=%b want 1 0", query_found, empty); end
      next_cycle(); n++;
    end
    n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL bdelay_timeout: bvalid=%b", bvalid); end
    next_cycle(); #1;
    n_checks++; if (query_found !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL bdelay_pop: got found=%b empty=%b want 0 1", query_found, empty); end
    next_cycle();
    w_rand = 0; b_delay = 0;
  endtask

  task automatic test_random();
    int r, c, n;
    bit e_push, e_wr;
    logic [LW-1:0] e_rd;
    w_rand = 1; aw_low = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b_delay = $urandom_range(0, 3);
      push  = ($urandom_range(0, 2) == 0);
      pline = {LABW'($urandom_range(1, 6)), rand_line()};
      write = ($urandom_range(0, 2) == 0);
      query_label = LABW'($urandom_range(1, 6));
      query_wdata = rand_line();
      query_wbe   = $urandom();
      #1;
      r = find_young(query_label);
      c = find_coal(pline[LW +: LABW]);
      e_push = push && (c >= 0 || mq.size() < D);
      e_wr   = write && r >= 0 && !(r == 0 && m_drain);
      e_rd   = (r >= 0) ? mq[r].data : '0;
      n_checks++; if (pushed !== e_push) begin n_fail++; $display("FAIL rnd_pushed@%0d: got %b want %b", cyc, pushed, e_push); end
      n_checks++; if (written !== e_wr) begin n_fail++; $display("FAIL rnd_written@%0d: got %b want %b", cyc, written, e_wr); end
      n_checks++; if (query_found !== (r >= 0)) begin n_fail++; $display("FAIL rnd_found@%0d: got %b want %b", cyc, query_found, (r >= 0)); end
      n_checks++; if (query_on_pop !== (r == 0 && m_drain)) begin
        n_fail++; $display("FAIL rnd_on_pop@%0d: got %b want %b", cyc, query_on_pop, (r == 0 && m_drain)); end
      n_checks++; if (query_rdata !== e_rd) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, query_rdata, e_rd); end
      n_checks++; if (full !== (mq.size() == D)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b want %b", cyc, full, (mq.size() == D)); end
      n_checks++; if (empty !== (mq.size() == 0 && !m_drain)) begin
        n_fail++; $display("FAIL rnd_empty@%0d: got %b want %b", cyc, empty, (mq.size() == 0 && !m_drain)); end
      next_cycle();
    end
    idle_in();
    n = 0;
    while (empty !== 1'b1 && n < 600) begin next_cycle(); n++; end
    #1;
    n_checks++; if (empty !== 1'b1 || mq.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: got empty=%b model lines=%0d want 1 0", empty, mq.size()); end
    w_rand = 0; b_delay = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    logic [LABW-1:0] lab;
    int s0, n;
    aw_low = 0; w_rand = 0; b_delay = 0;
    lab = LABW'($urandom_range(1000, 2000));
    s0 = beat_log.size();
    push = 1'b1; pline = {lab, rand_line()};
    next_cycle(); idle_in();
    n = 0;
    while ((beat_log.size() - s0) < 3 && n < 30) begin next_cycle(); n++; end
    n_checks++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL mid_burst_setup: got wvalid=%b want 1", wvalid); end
    rst = 1'b1;
    next_cycle(); #1;
    n_checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_valid: got aw=%b w=%b want 0 0", awvalid, wvalid); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_state: got empty=%b full=%b want 1 0", empty, full); end
    query_label = lab; #1;
    n_checks++; if (query_found !== 1'b0) begin n_fail++; $display("FAIL mid_rst_entry: got found=%b want 0", query_found); end
    rst = 1'b0; idle_in();
    next_cycle(); next_cycle(); #1;
    n_checks++; if (empty !== 1'b1 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: got empty=%b awvalid=%b want 1 0", empty, awvalid); end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_single_push();
    test_full_coalesce_merge();
    test_bdelay();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
